ecpa: RTL and testbench

Elliptic-curve point adder over a 256-bit prime field, for short-Weierstrass curves with a = 0 (secp256k1-class, y² = x³ + b). It takes two points in homogeneous projective coordinates (X:Y:Z) and a modulus p, and returns their sum in projective form. It handles the point at infinity, point doubling and P + (−P). It sits below the scalar-multiplication controller, which drives one addition at a time through a start/done handshake.

---
 rtl/ecpa.sv | 229 ++++++++++++++++++++++
 tb/tb_ecpa.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ecpa.sv
// Projective point adder for a = 0 short-Weierstrass curves over a 256-bit prime field.
// Field ops are microcoded over a 16-entry register file with one shared bit-serial multiplier.
module ecpa (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [255:0] p,
  input  logic [255:0] X1,
  input  logic [255:0] Y1,
  input  logic [255:0] Z1,
  input  logic [255:0] X2,
  input  logic [255:0] Y2,
  input  logic [255:0] Z2,
  output logic [255:0] X3,
  output logic [255:0] Y3,
  output logic [255:0] Z3,
  output logic         o_done
);

  typedef enum logic [1:0] {StIdle, StLoad, StCalc, StDone} state_e;
  typedef enum logic [2:0] {OpAdd, OpSub, OpMul, OpBr, OpOut} op_e;

  typedef struct packed {
    op_e        op;
    logic [3:0] d;
    logic [3:0] a;
    logic [3:0] b;
  } uop_t;

  localparam logic [5:0] AddStart = 6'd8;
  localparam logic [5:0] DblStart = 6'd24;

  // r0..r5 = X1 Y1 Z1 X2 Y2 Z2; r6 = u, r7 = v, r8 = X1*Z2, r9 = w after the common prefix.
  function automatic uop_t ucode(input logic [5:0] pc);
    uop_t r;
    case (pc)
      6'd0:  r = '{OpMul, 4'd6,  4'd4,  4'd2};
      6'd1:  r = '{OpMul, 4'd7,  4'd1,  4'd5};
      6'd2:  r = '{OpSub, 4'd6,  4'd6,  4'd7};
      6'd3:  r = '{OpMul, 4'd7,  4'd3,  4'd2};
      6'd4:  r = '{OpMul, 4'd8,  4'd0,  4'd5};
      6'd5:  r = '{OpSub, 4'd7,  4'd7,  4'd8};
      6'd6:  r = '{OpMul, 4'd9,  4'd2,  4'd5};
      6'd7:  r = '{OpBr,  4'd0,  4'd0,  4'd0};
      // General addition
      6'd8:  r = '{OpMul, 4'd10, 4'd7,  4'd7};
      6'd9:  r = '{OpMul, 4'd11, 4'd10, 4'd7};
      6'd10: r = '{OpMul, 4'd12, 4'd10, 4'd8};
      6'd11: r = '{OpMul, 4'd13, 4'd6,  4'd6};
      6'd12: r = '{OpMul, 4'd13, 4'd13, 4'd9};
      6'd13: r = '{OpSub, 4'd13, 4'd13, 4'd11};
      6'd14: r = '{OpSub, 4'd13, 4'd13, 4'd12};
      6'd15: r = '{OpSub, 4'd13, 4'd13, 4'd12};
      6'd16: r = '{OpMul, 4'd14, 4'd7,  4'd13};
      6'd17: r = '{OpSub, 4'd12, 4'd12, 4'd13};
      6'd18: r = '{OpMul, 4'd12, 4'd6,  4'd12};
      6'd19: r = '{OpMul, 4'd10, 4'd1,  4'd5};
      6'd20: r = '{OpMul, 4'd10, 4'd11, 4'd10};
      6'd21: r = '{OpSub, 4'd12, 4'd12, 4'd10};
      6'd22: r = '{OpMul, 4'd15, 4'd11, 4'd9};
      6'd23: r = '{OpOut, 4'd14, 4'd12, 4'd15};
      // Doubling of P1
      6'd24: r = '{OpMul, 4'd10, 4'd0,  4'd0};
      6'd25: r = '{OpAdd, 4'd11, 4'd10, 4'd10};
      6'd26: r = '{OpAdd, 4'd10, 4'd11, 4'd10};
      6'd27: r = '{OpMul, 4'd11, 4'd1,  4'd2};
      6'd28: r = '{OpMul, 4'd12, 4'd0,  4'd1};
      6'd29: r = '{OpMul, 4'd12, 4'd12, 4'd11};
      6'd30: r = '{OpMul, 4'd13, 4'd10, 4'd10};
      6'd31: r = '{OpAdd, 4'd14, 4'd12, 4'd12};
      6'd32: r = '{OpAdd, 4'd14, 4'd14, 4'd14};
      6'd33: r = '{OpAdd, 4'd15, 4'd14, 4'd14};
      6'd34: r = '{OpSub, 4'd13, 4'd13, 4'd15};
      6'd35: r = '{OpMul, 4'd15, 4'd13, 4'd11};
      6'd36: r = '{OpAdd, 4'd15, 4'd15, 4'd15};
      6'd37: r = '{OpSub, 4'd14, 4'd14, 4'd13};
      6'd38: r = '{OpMul, 4'd14, 4'd10, 4'd14};
      6'd39: r = '{OpMul, 4'd10, 4'd1,  4'd1};
      6'd40: r = '{OpMul, 4'd12, 4'd11, 4'd11};
      6'd41: r = '{OpMul, 4'd10, 4'd10, 4'd12};
      6'd42: r = '{OpAdd, 4'd10, 4'd10, 4'd10};
      6'd43: r = '{OpAdd, 4'd10, 4'd10, 4'd10};
      6'd44: r = '{OpAdd, 4'd10, 4'd10, 4'd10};
      6'd45: r = '{OpSub, 4'd14, 4'd14, 4'd10};
      6'd46: r = '{OpMul, 4'd12, 4'd12, 4'd11};
      6'd47: r = '{OpAdd, 4'd12, 4'd12, 4'd12};
      6'd48: r = '{OpAdd, 4'd12, 4'd12, 4'd12};
      6'd49: r = '{OpAdd, 4'd12, 4'd12, 4'd12};
      6'd50: r = '{OpOut, 4'd15, 4'd14, 4'd12};
      default: r = '{OpOut, 4'd0, 4'd0, 4'd0};
    endcase
    return r;
  endfunction

  // x < 2m assumed; one conditional subtraction brings it into [0, m).
  function automatic logic [255:0] mod_red(input logic [256:0] x, input logic [255:0] m);
    return (x >= {1'b0, m}) ? 256'(x - {1'b0, m}) : x[255:0];
  endfunction

  state_e       state;
  logic [5:0]   pc;
  logic [255:0] p_q;
  logic [255:0] rf [16];

  logic         mul_busy;
  logic [7:0]   mul_cnt;
  logic [255:0] mul_a;
  logic [255:0] mul_b;
  logic [255:0] acc;

  uop_t         uop;
  logic [255:0] opa, opb, add_res, sub_res, acc_dbl, acc_nxt;

  always_comb begin
    uop     = ucode(pc);
    opa     = rf[uop.a];
    opb     = rf[uop.b];
    add_res = mod_red({1'b0, opa} + {1'b0, opb}, p_q);
    sub_res = (opa >= opb) ? opa - opb : opa - opb + p_q;
    acc_dbl = mod_red({acc, 1'b0}, p_q);
    acc_nxt = mul_b[255] ? mod_red({1'b0, acc_dbl} + {1'b0, mul_a}, p_q) : acc_dbl;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= StIdle;
      pc       <= '0;
      mul_busy <= 1'b0;
      X3       <= '0;
      Y3       <= '0;
      Z3       <= '0;
      o_done   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (i_start) begin
            p_q   <= p;
            rf[0] <= X1;
            rf[1] <= Y1;
            rf[2] <= Z1;
            rf[3] <= X2;
            rf[4] <= Y2;
            rf[5] <= Z2;
            state <= StLoad;
          end
        end
        StLoad: begin
          if (rf[2] == '0) begin
            X3     <= rf[3];
            Y3     <= rf[4];
            Z3     <= rf[5];
            o_done <= 1'b1;
            state  <= StDone;
          end else if (rf[5] == '0) begin
            X3     <= rf[0];
            Y3     <= rf[1];
            Z3     <= rf[2];
            o_done <= 1'b1;
            state  <= StDone;
          end else begin
            pc       <= '0;
            mul_busy <= 1'b0;
            state    <= StCalc;
          end
        end
        StCalc: begin
          case (uop.op)
            OpAdd: begin
              rf[uop.d] <= add_res;
              pc        <= pc + 6'd1;
            end
            OpSub: begin
              rf[uop.d] <= sub_res;
              pc        <= pc + 6'd1;
            end
            OpMul: begin
              // Operands are latched up front so the destination may alias a source.
              if (!mul_busy) begin
                mul_a    <= opa;
                mul_b    <= opb;
                acc      <= '0;
                mul_cnt  <= 8'd255;
                mul_busy <= 1'b1;
              end else begin
                acc     <= acc_nxt;
                mul_b   <= {mul_b[254:0], 1'b0};
                mul_cnt <= mul_cnt - 8'd1;
                if (mul_cnt == 8'd0) begin
                  rf[uop.d] <= acc_nxt;
                  mul_busy  <= 1'b0;
                  pc        <= pc + 6'd1;
                end
              end
            end
            OpBr: begin
              if (rf[7] != '0) begin
                pc <= AddStart;
              end else if (rf[6] == '0) begin
                pc <= DblStart;
              end else begin
                X3     <= '0;
                Y3     <= 256'd1;
                Z3     <= '0;
                o_done <= 1'b1;
                state  <= StDone;
              end
            end
            OpOut: begin
              X3     <= rf[uop.d];
              Y3     <= rf[uop.a];
              Z3     <= rf[uop.b];
              o_done <= 1'b1;
              state  <= StDone;
            end
            default: state <= StIdle;
          endcase
        end
        StDone: begin
          if (!i_start) begin
            o_done <= 1'b0;
            state  <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ecpa.sv
// Directed bench for ecpa: infinity shortcuts, general add, doubling, P + (-P), mid-op reset.
module tb_ecpa;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_start;
  logic [255:0] p, X1, Y1, Z1, X2, Y2, Z2;
  logic [255:0] X3, Y3, Z3;
  logic         o_done;

  int checks = 0;
  int errors = 0;
  int cyc;

  localparam logic [255:0] PK1 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] GX =
    256'h4b82bf5f6655ac6be5f66fc070f0f31838cb375027040d0ab1b5680c84f43127;
  localparam logic [255:0] GY =
    256'h01c08b7d0e94c0dcb7defda9224f53e61e47fe20ad2420a71de13d393f2b9399;

  ecpa dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(i_start),
    .p      (p),
    .X1     (X1),
    .Y1     (Y1),
    .Z1     (Z1),
    .X2     (X2),
    .Y2     (Y2),
    .Z2     (Z2),
    .X3     (X3),
    .Y3     (Y3),
    .Z3     (Z3),
    .o_done (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pt(input string tag, input logic [255:0] ex, ey, ez);
    chk({tag, ".X3"}, X3, ex);
    chk({tag, ".Y3"}, Y3, ey);
    chk({tag, ".Z3"}, Z3, ez);
  endtask

  task automatic set_ops(input logic [255:0] m, a1, b1, c1, a2, b2, c2);
    p = m; X1 = a1; Y1 = b1; Z1 = c1; X2 = a2; Y2 = b2; Z2 = c2;
  endtask

  // Raise start, scramble the inputs once captured, wait (bounded) for o_done.
  task automatic run_req(input string tag, output int n);
    i_start = 1'b1;
    tick();
    X1 = 256'd9; Y1 = 256'd9; Z1 = 256'd0; X2 = 256'd3; Y2 = 256'd2; Z2 = 256'd0;
    n = 1;
    while (!o_done && n < 20000) begin
      tick();
      n++;
    end
    checks++;
    assert (o_done === 1'b1 && n <= 16384)
    else begin
      errors++;
      $error("FAIL %s.latency observed=%0d cycles done=%b expected<=16384 done=1", tag, n, o_done);
    end
  endtask

  task automatic release_req(input string tag);
    i_start = 1'b0;
    tick();
    chk({tag, ".done_drop"}, {255'd0, o_done}, 256'd0);
  endtask

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    set_ops(256'd23, '0, '0, '0, '0, '0, '0);
    tick();
    tick();
    chk_pt("reset", '0, '0, '0);
    chk("reset.done", {255'd0, o_done}, 256'd0);
    i_rst = 1'b0;
    tick();

    // Infinity + point on secp256k1: exact cycle timing and done held while start is high.
    set_ops(PK1, 256'd0, 256'd1, 256'd0, GX, GY, 256'd1);
    i_start = 1'b1;
    tick();
    chk("inf1.done_c1", {255'd0, o_done}, 256'd0);
    X2 = 256'd5;
    tick();
    chk("inf1.done_c2", {255'd0, o_done}, 256'd1);
    chk_pt("inf1", GX, GY, 256'd1);
    tick(); tick(); tick();
    chk("inf1.done_hold", {255'd0, o_done}, 256'd1);
    chk_pt("inf1.hold", GX, GY, 256'd1);
    release_req("inf1");
    chk_pt("inf1.idle", GX, GY, 256'd1);
    tick();

    // General addition mod 23
    set_ops(256'd23, 256'd5, 256'd17, 256'd1, 256'd7, 256'd13, 256'd1);
    run_req("add", cyc);
    chk_pt("add", 256'd5, 256'd1, 256'd8);
    release_req("add");
    chk_pt("add.idle", 256'd5, 256'd1, 256'd8);
    tick();

    // Doubling mod 23
    set_ops(256'd23, 256'd5, 256'd17, 256'd1, 256'd5, 256'd17, 256'd1);
    run_req("dbl", cyc);
    chk_pt("dbl", 256'd12, 256'd7, 256'd20);
    release_req("dbl");
    tick();

    // P + (-P) mod 23
    set_ops(256'd23, 256'd5, 256'd17, 256'd1, 256'd5, 256'd6, 256'd1);
    run_req("inv", cyc);
    chk_pt("inv", 256'd0, 256'd1, 256'd0);
    release_req("inv");
    tick();

    // Second operand at infinity: shortcut latency of two edges
    set_ops(256'd23, 256'd7, 256'd13, 256'd1, 256'd3, 256'd4, 256'd0);
    run_req("inf2", cyc);
    chk("inf2.cycles", 256'(cyc), 256'd2);
    chk_pt("inf2", 256'd7, 256'd13, 256'd1);
    release_req("inf2");
    tick();

    // Reset partway through a general addition, then rerun it
    set_ops(256'd23, 256'd5, 256'd17, 256'd1, 256'd7, 256'd13, 256'd1);
    i_start = 1'b1;
    repeat (300) tick();
    i_rst = 1'b1;
    tick();
    chk_pt("rst_mid", '0, '0, '0);
    chk("rst_mid.done", {255'd0, o_done}, 256'd0);
    i_rst   = 1'b0;
    i_start = 1'b0;
    tick();
    chk("rst_mid.idle_done", {255'd0, o_done}, 256'd0);
    set_ops(256'd23, 256'd5, 256'd17, 256'd1, 256'd7, 256'd13, 256'd1);
    run_req("rerun", cyc);
    chk_pt("rerun", 256'd5, 256'd1, 256'd8);
    release_req("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
